im_loader: RTL



---
 rtl/im_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// rtl/im_loader.sv - byte-stream instruction RAM loader with XOR-checked load sessions
module im_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   count_n;
    logic [ADDR_W:0]   count_val;
    logic [7:0]        hi_byte;
    logic [7:0]        xor_acc;

    // Per-edge actions decided by the FSM and carried out by the datapath
    logic do_start;
    logic do_count;
    logic do_hi;
    logic do_lo;
    logic do_good;
    logic do_bad;

    // A COUNT byte of zero stands for a full RAM load
    assign count_val = (in_data == 8'd0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(in_data);

    // State register; reset returns to IDLE immediately, even mid-load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake and action decode; in_ready depends on state only
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        do_start  = 1'b0;
        do_count  = 1'b0;
        do_hi     = 1'b0;
        do_lo     = 1'b0;
        do_good   = 1'b0;
        do_bad    = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    do_start  = 1'b1;
                    state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    do_count  = 1'b1;
                    state_nxt = S_HI;
                end
            end
            S_HI: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    do_hi     = 1'b1;
                    state_nxt = S_LO;
                end
            end
            S_LO: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    do_lo     = 1'b1;
                    state_nxt = (remaining == (ADDR_W+1)'(1)) ? S_CHK : S_HI;
                end
            end
            S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    if (in_data == xor_acc) begin
                        do_good   = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        do_bad    = 1'b1;
                        state_nxt = S_ERR;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Session datapath: counters, checksum accumulator and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr         <= '0;
            remaining    <= '0;
            count_n      <= '0;
            hi_byte      <= '0;
            xor_acc      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            if (do_start) begin
                addr         <= '0;
                xor_acc      <= '0;
                done         <= 1'b0;
                err          <= 1'b0;
                words_loaded <= '0;
            end
            if (do_count) begin
                remaining <= count_val;
                count_n   <= count_val;
            end
            if (do_hi) begin
                hi_byte <= in_data;
                xor_acc <= xor_acc ^ in_data;
            end
            if (do_lo) begin
                xor_acc   <= xor_acc ^ in_data;
                addr      <= addr + ADDR_W'(1);
                remaining <= remaining - (ADDR_W+1)'(1);
            end
            if (do_good) begin
                done         <= 1'b1;
                words_loaded <= count_n;
            end
            if (do_bad) begin
                err <= 1'b1;
            end
        end
    end

    // RAM write port: one word per low-byte transfer; contents survive reset
    always_ff @(posedge clk) begin
        if (do_lo) begin
            mem[addr] <= DATA_W'({hi_byte, in_data});
        end
    end

    // Combinational read port, masked beyond the verified word count
    always_comb begin
        instr = '0;
        if ({1'b0, pc} < words_loaded) begin
            instr = mem[pc];
        end
    end

endmodule
